// File: rtl/disp_ctrl.sv
// Eight-digit multiplexed seven-segment controller: captures BCD digits while the
// calculator prints, then scans them out with leading-zero blanking and an "Err" mode.

module disp_ctrl_digit #(
  parameter int DW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] dig,
  output logic          is_zero
);
  logic [DW-1:0] dig_d, dig_q;

  always_comb begin
    dig_d = dig_q;
    if (wr_en) dig_d = wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) dig_q <= '0;
    else        dig_q <= dig_d;
  end

  assign dig     = dig_q;
  assign is_zero = (dig_q == '0);
endmodule

module disp_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy_led,
  output logic       frame_done
);
  localparam int NUM_DIG = 8;
  localparam logic [1:0] ST_ERR  = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_PRT  = 2'b11;
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [NUM_DIG-1:0][3:0] dig_vec;
  logic [NUM_DIG-1:0]      dig_zero;
  logic [NUM_DIG-1:0]      wr_en;
  logic [NUM_DIG-1:0]      lz;
  logic                    cap_ok;

  logic [15:0] div_cnt_d, div_cnt_q;
  logic [2:0]  scan_idx_d, scan_idx_q;
  logic        err_d, err_q;
  logic [7:0]  an_d, an_q;
  logic [6:0]  seg_d, seg_q;
  logic        dp_d, dp_q;
  logic        busy_led_d, busy_led_q;
  logic        frame_done_d, frame_done_q;

  // Captures are held off for the whole error window so dig survives intact.
  assign cap_ok = (status == ST_PRT) && (pos != 4'd0) && (pos <= 4'd8) && !err_q;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    assign wr_en[i] = cap_ok && (pos == 4'(i + 1));
    disp_ctrl_digit #(.DW(4)) u_dig (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en[i]),
      .wr_data (data),
      .dig     (dig_vec[i]),
      .is_zero (dig_zero[i])
    );
  end

  function automatic logic [6:0] enc7(input logic [3:0] v);
    case (v)
      4'd0:    enc7 = 7'h40;
      4'd1:    enc7 = 7'h79;
      4'd2:    enc7 = 7'h24;
      4'd3:    enc7 = 7'h30;
      4'd4:    enc7 = 7'h19;
      4'd5:    enc7 = 7'h12;
      4'd6:    enc7 = 7'h02;
      4'd7:    enc7 = 7'h78;
      4'd8:    enc7 = 7'h00;
      4'd9:    enc7 = 7'h10;
      default: enc7 = 7'h7F;
    endcase
  endfunction

  // lz[i]: dig[i] and every more-significant digit are zero.
  always_comb begin
    logic acc;
    lz  = '0;
    acc = 1'b1;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      acc   = acc & dig_zero[i];
      lz[i] = acc;
    end
  end

  always_comb begin
    div_cnt_d    = (div_cnt_q == DIV_LAST) ? 16'd0 : div_cnt_q + 16'd1;
    scan_idx_d   = (div_cnt_q == DIV_LAST) ? scan_idx_q + 3'd1 : scan_idx_q;
    err_d        = (status == ST_ERR);
    busy_led_d   = (status == ST_BUSY);
    frame_done_d = cap_ok && (pos == 4'd8);
    dp_d         = 1'b1;
    an_d         = ~(8'b1 << scan_idx_q);
    seg_d        = 7'h7F;
    if (err_q) begin
      case (scan_idx_q)
        3'd2:       seg_d = 7'h06;
        3'd1, 3'd0: seg_d = 7'h2F;
        default:    seg_d = 7'h7F;
      endcase
    end else if ((scan_idx_q != 3'd0) && lz[scan_idx_q]) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = enc7(dig_vec[scan_idx_q]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt_q    <= '0;
      scan_idx_q   <= '0;
      err_q        <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      busy_led_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      scan_idx_q   <= scan_idx_d;
      err_q        <= err_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      busy_led_q   <= busy_led_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign busy_led   = busy_led_q;
  assign frame_done = frame_done_q;
endmodule
